// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one memory port between CPU instruction and data buses, one transaction in flight.
// Optional CPU_ARB_ROUND_ROBIN_EN alternates contested grants instead of fixed data-first priority.
module cpu_bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    input  logic        cpud_request,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_next;
    logic        pi_v, pd_v, pd_write;
    logic [31:0] pi_addr, pd_addr, pd_wdata;
    logic [3:0]  pd_be;
    logic        i_want, d_want, can_grant, d_first, grant_i, grant_d;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        d_write;
    logic [3:0]  d_be;
    // A request arriving this cycle is granted straight from the inputs.
    assign i_want  = pi_v | cpui_request;
    assign d_want  = pd_v | cpud_request;
    assign i_addr  = cpui_request ? cpui_addr : pi_addr;
    assign d_addr  = cpud_request ? cpud_addr : pd_addr;
    assign d_write = cpud_request ? cpud_write : pd_write;
    assign d_be    = cpud_request ? cpud_byte_enable : pd_be;
    assign d_wdata = cpud_request ? cpud_wdata : pd_wdata;
    assign cpui_ack   = (state == BUSY_I) && mem_ack;
    assign cpud_ack   = (state == BUSY_D) && mem_ack;
    assign cpui_rdata = cpui_ack ? mem_rdata : 32'h0;
    assign cpud_rdata = cpud_ack ? mem_rdata : 32'h0;
    assign can_grant  = (state == IDLE) || cpui_ack || cpud_ack;
`ifdef CPU_ARB_ROUND_ROBIN_EN
    logic last_i;
    // Only contested grants move the turn, so uncontested traffic cannot starve a side.
    assign d_first = last_i;
    always_ff @(posedge clock) begin
        if (reset)
            last_i <= 1'b1;
        else if (can_grant && i_want && d_want)
            last_i <= grant_i;
    end
`else
    assign d_first = 1'b1;
`endif
    assign grant_d = can_grant && d_want && (!i_want || d_first);
    assign grant_i = can_grant && i_want && !grant_d;
    always_comb begin
        state_next = grant_d ? BUSY_D : grant_i ? BUSY_I : can_grant ? IDLE : state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            pi_v            <= 1'b0;
            pd_v            <= 1'b0;
            pi_addr         <= '0;
            pd_addr         <= '0;
            pd_write        <= 1'b0;
            pd_be           <= '0;
            pd_wdata        <= '0;
            mem_request     <= 1'b0;
            mem_addr        <= '0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
        end else begin
            state       <= state_next;
            pi_v        <= i_want && !grant_i;
            pd_v        <= d_want && !grant_d;
            mem_request <= grant_i || grant_d;
            if (cpui_request)
                pi_addr <= cpui_addr;
            if (cpud_request) begin
                pd_addr  <= cpud_addr;
                pd_write <= cpud_write;
                pd_be    <= cpud_byte_enable;
                pd_wdata <= cpud_wdata;
            end
            if (grant_d) begin
                mem_addr        <= d_addr;
                mem_write       <= d_write;
                mem_byte_enable <= d_be;
                mem_wdata       <= d_wdata;
            end else if (grant_i) begin
                mem_addr        <= i_addr;
                mem_write       <= 1'b0;
                mem_byte_enable <= 4'b0000;
                mem_wdata       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed checks of capture, priority, ack routing, back-to-back and reset.
module tb_cpu_bus_arbiter;
    logic        clk = 0, reset = 1;
    logic        cpui_request = 0, cpud_request = 0, cpud_write = 0, mem_ack = 0;
    logic [31:0] cpui_addr = 0, cpud_addr = 0, cpud_wdata = 0, mem_rdata = 0;
    logic [3:0]  cpud_byte_enable = 0;
    logic [31:0] cpui_rdata, cpud_rdata, mem_addr, mem_wdata;
    logic        cpui_ack, cpud_ack, mem_request, mem_write;
    logic [3:0]  mem_byte_enable;
    int checks = 0, errors = 0;

    cpu_bus_arbiter dut (
        .clock(clk), .reset(reset),
        .cpui_request(cpui_request), .cpui_addr(cpui_addr), .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
        .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
        .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata), .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
        .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; pulses default back to 0 each cycle.
    task automatic step();
        @(negedge clk);
        cpui_request = 0;
        cpud_request = 0;
        mem_ack      = 0;
        mem_rdata    = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
        checks++; if ({mem_request, mem_write, mem_byte_enable} !== 6'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {mem_request, mem_write, mem_byte_enable}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata}); end
        checks++; if ({cpui_ack, cpud_ack, cpui_rdata, cpud_rdata} !== 66'h0) begin errors++; $display("FAIL reset_cpu: got %h want 0", {cpui_ack, cpud_ack, cpui_rdata, cpud_rdata}); end
    endtask

    task automatic test_single_i();
        step(); cpui_request = 1; cpui_addr = 32'h100;
        step(); #1;
        checks++; if ({mem_request, mem_addr, mem_write, mem_byte_enable} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin errors++; $display("FAIL i_memreq: got %b %h %b %h want 1 00000100 0 0", mem_request, mem_addr, mem_write, mem_byte_enable); end
        step(); #1;
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL i_pulse: got %b want 0", mem_request); end
        step(); mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
        checks++; if ({cpui_ack, cpui_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL i_ack: got %b %h want 1 deadbeef", cpui_ack, cpui_rdata); end
        checks++; if ({cpud_ack, cpud_rdata} !== 33'h0) begin errors++; $display("FAIL i_ack_d_quiet: got %b %h want 0 0", cpud_ack, cpud_rdata); end
        step(); #1;
        checks++; if ({cpui_ack, mem_request, mem_addr} !== {2'b00, 32'h100}) begin errors++; $display("FAIL i_after: got %b %b %h want 0 0 00000100", cpui_ack, mem_request, mem_addr); end
    endtask

    task automatic test_single_d();
        step(); cpud_request = 1; cpud_addr = 32'h2000; cpud_write = 1; cpud_byte_enable = 4'b0011; cpud_wdata = 32'h12345678;
        step(); #1;
        checks++; if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata} !== {1'b1, 32'h2000, 1'b1, 4'b0011, 32'h12345678}) begin errors++; $display("FAIL d_memreq: got %b %h %b %h %h", mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata); end
        step(); mem_ack = 1; mem_rdata = 32'h0000A5A5; #1;
        checks++; if ({cpud_ack, cpud_rdata, cpui_ack} !== {1'b1, 32'h0000A5A5, 1'b0}) begin errors++; $display("FAIL d_ack: got %b %h %b want 1 0000a5a5 0", cpud_ack, cpud_rdata, cpui_ack); end
        step(); #1;
        checks++; if ({cpud_ack, cpui_ack, mem_request} !== 3'b000) begin errors++; $display("FAIL d_after: got %b want 000", {cpud_ack, cpui_ack, mem_request}); end
    endtask

    // Both sides request together; first_d says which side must win.
    task automatic contested(input string tag, input bit first_d);
        logic [31:0] a1, a2;
        a1 = first_d ? 32'h400 : 32'h300;
        a2 = first_d ? 32'h300 : 32'h400;
        step(); cpui_request = 1; cpui_addr = 32'h300; cpud_request = 1; cpud_addr = 32'h400; cpud_write = 0; cpud_byte_enable = 0; cpud_wdata = 0;
        step(); #1;
        checks++; if ({mem_request, mem_addr} !== {1'b1, a1}) begin errors++; $display("FAIL %s_first_req: got %b %h want 1 %h", tag, mem_request, mem_addr, a1); end
        step();
        step(); mem_ack = 1; mem_rdata = 32'h11111111; #1;
        checks++; if ({cpud_ack, cpui_ack} !== {first_d, !first_d}) begin errors++; $display("FAIL %s_first_ack: got d=%b i=%b want d=%b", tag, cpud_ack, cpui_ack, first_d); end
        step(); #1;
        checks++; if ({mem_request, mem_addr} !== {1'b1, a2}) begin errors++; $display("FAIL %s_second_req: got %b %h want 1 %h", tag, mem_request, mem_addr, a2); end
        step();
        step(); mem_ack = 1; mem_rdata = 32'h22222222; #1;
        checks++; if ({cpud_ack, cpui_ack, first_d ? cpui_rdata : cpud_rdata} !== {!first_d, first_d, 32'h22222222}) begin errors++; $display("FAIL %s_second_ack: got d=%b i=%b %h", tag, cpud_ack, cpui_ack, first_d ? cpui_rdata : cpud_rdata); end
        step();
    endtask

    task automatic test_simultaneous();
        contested("sim1", 1'b1);
`ifdef CPU_ARB_ROUND_ROBIN_EN
        contested("sim2", 1'b0);
`else
        contested("sim2", 1'b1);
`endif
    endtask

    task automatic test_d_during_i();
        step(); cpui_request = 1; cpui_addr = 32'h500;
        step(); cpud_request = 1; cpud_addr = 32'h600; cpud_write = 1; cpud_byte_enable = 4'hF; cpud_wdata = 32'hCAFEF00D; #1;
        checks++; if ({mem_request, mem_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL bd_i_req: got %b %h want 1 00000500", mem_request, mem_addr); end
        step(); cpud_addr = 32'hBAD; cpud_write = 0; cpud_byte_enable = 0; cpud_wdata = 0; #1;
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL bd_hold: got %b want 0", mem_request); end
        step(); #1;
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL bd_hold2: got %b want 0", mem_request); end
        step(); mem_ack = 1; mem_rdata = 32'h55555555; #1;
        checks++; if ({cpui_ack, cpud_ack, cpui_rdata} !== {2'b10, 32'h55555555}) begin errors++; $display("FAIL bd_i_ack: got %b %b %h", cpui_ack, cpud_ack, cpui_rdata); end
        step(); #1;
        checks++; if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata} !== {1'b1, 32'h600, 1'b1, 4'hF, 32'hCAFEF00D}) begin errors++; $display("FAIL bd_d_req: got %b %h %b %h %h", mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata); end
        step(); mem_ack = 1; #1;
        checks++; if ({cpud_ack, cpui_ack} !== 2'b10) begin errors++; $display("FAIL bd_d_ack: got %b want 10", {cpud_ack, cpui_ack}); end
        step();
    endtask

    task automatic test_reset_mid();
        step(); cpui_request = 1; cpui_addr = 32'h700;
        step(); #1;
        checks++; if (mem_request !== 1'b1) begin errors++; $display("FAIL rm_req: got %b want 1", mem_request); end
        step(); reset = 1;
        step(); reset = 0; #1;
        checks++; if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata} !== 70'h0) begin errors++; $display("FAIL rm_outputs: got %b %h %b %h %h want zeros", mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata); end
        step(); mem_ack = 1; mem_rdata = 32'h77777777; #1;
        checks++; if ({cpui_ack, cpud_ack, cpui_rdata, cpud_rdata} !== 66'h0) begin errors++; $display("FAIL rm_stale_ack: got %b %b %h %h want zeros", cpui_ack, cpud_ack, cpui_rdata, cpud_rdata); end
        step(); cpud_request = 1; cpud_addr = 32'h800; cpud_write = 0; cpud_byte_enable = 0; cpud_wdata = 0; #1;
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rm_no_req: got %b want 0", mem_request); end
        step(); #1;
        checks++; if ({mem_request, mem_addr} !== {1'b1, 32'h800}) begin errors++; $display("FAIL rm_next_req: got %b %h want 1 00000800", mem_request, mem_addr); end
        step(); mem_ack = 1; mem_rdata = 32'h88888888; #1;
        checks++; if ({cpud_ack, cpud_rdata} !== {1'b1, 32'h88888888}) begin errors++; $display("FAIL rm_next_ack: got %b %h want 1 88888888", cpud_ack, cpud_rdata); end
        step();
    endtask

    task automatic test_stray_ack();
        step(); mem_ack = 1; mem_rdata = 32'hFFFFFFFF; #1;
        checks++; if ({cpui_ack, cpud_ack, cpui_rdata, cpud_rdata} !== 66'h0) begin errors++; $display("FAIL stray_ack: got %b %b %h %h want zeros", cpui_ack, cpud_ack, cpui_rdata, cpud_rdata); end
        step(); cpui_request = 1; cpui_addr = 32'h900; #1;
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL stray_no_req: got %b want 0", mem_request); end
        step(); #1;
        checks++; if ({mem_request, mem_addr} !== {1'b1, 32'h900}) begin errors++; $display("FAIL stray_idle: got %b %h want 1 00000900", mem_request, mem_addr); end
        step(); mem_ack = 1; mem_rdata = 32'h99999999; #1;
        checks++; if ({cpui_ack, cpui_rdata} !== {1'b1, 32'h99999999}) begin errors++; $display("FAIL stray_ack_after: got %b %h", cpui_ack, cpui_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_single_d();
        test_simultaneous();
        test_d_during_i();
        test_reset_mid();
        test_stray_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares one memory port between the CPU instruction bus (cpui_*) and data bus (cpud_*). It captures single-cycle requests from either side and keeps at most one transaction outstanding on the memory port. When both sides are waiting it picks a winner by priority. The memory acknowledge and read data are routed back to whichever side owns the transaction. The block sits between the `cpu` top level and the memory/peripheral fabric.

## Interface
- No parameters; all buses are 32-bit data/address, 4-bit byte enable.
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpui_request  in  1  instruction read request, one-cycle pulse
- cpui_addr  in  32  instruction address, valid with cpui_request
- cpui_rdata  out  32  instruction read data, valid with cpui_ack
- cpui_ack  out  1  instruction transaction complete, one-cycle pulse
- cpud_request  in  1  data request, one-cycle pulse
- cpud_addr  in  32  data address
- cpud_write  in  1  1 = write, 0 = read
- cpud_byte_enable  in  4  write byte lanes
- cpud_wdata  in  32  write data
- cpud_rdata  out  32  data read data, valid with cpud_ack
- cpud_ack  out  1  data transaction complete, one-cycle pulse
- mem_request  out  1  memory request, one-cycle pulse
- mem_addr  out  32  memory address
- mem_write  out  1  memory write
- mem_byte_enable  out  4  memory byte lanes
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory transaction complete

## Operation
- **Pending capture.**
  - Each side has a pending register: valid bit plus the captured fields. For I: addr. For D: addr, write, byte_enable, wdata.
  - A request pulse sets the side's pending register in the same edge it is sampled.
  - Upstream rule: each side has at most one request outstanding until its ack. The bench must not violate this rule; behaviour under violation is unspecified.
- **States.**
  - IDLE: no transaction in flight.
  - BUSY_I / BUSY_D: the owning side's transaction is on the memory port.
- **IDLE transitions.**
  - If any pending (including a request arriving this cycle), grant the winner.
  - On grant: register the mem_* fields, pulse mem_request next cycle, go to BUSY_x, clear that side's pending valid.
  - The instruction side drives mem_write=0 and mem_byte_enable=4'b0000.
- **BUSY_x transitions.**
  - Wait for mem_ack. In the ack cycle, cpux_ack=1 and cpux_rdata=mem_rdata, both combinational.
  - In the same cycle, if another request is pending, grant it directly (BUSY_x → BUSY_y). Otherwise go to IDLE.
- **Priority when both are pending:** fixed data-first. See Configuration for the alternative.
- **Ack routing.**
  - Acks go only to the owner. The non-owner's rdata holds 0.
  - mem_ack in IDLE is ignored.
- **mem_addr/mem_wdata/mem_write/mem_byte_enable** hold their granted values until the next grant.
- **Reset.** Clears both pending registers and returns to IDLE. A transaction in flight is abandoned and its later mem_ack is ignored.

## Timing
- **Reset values:** mem_request=0, mem_addr=0, mem_write=0, mem_byte_enable=0, mem_wdata=0, cpui_ack=0, cpud_ack=0, cpui_rdata=0, cpud_rdata=0.
- **Request to memory:** request at cycle N (arbiter IDLE, wins) → mem_request at N+1.
- **Memory to requester:** mem_ack at cycle M → cpux_ack at M (zero added latency).
- **Back-to-back:** mem_ack at M with the other side pending → next mem_request at M+1. There is no idle gap between consecutive transactions.
- **Simultaneous requests:** both request at N in IDLE → winner's mem_request at N+1, loser's at ack+1.
- **Request during BUSY:** captured into pending and served after the current ack.
- **mem_request** is never asserted while a transaction is outstanding.

## Configuration
- **Macro:** CPU_ARB_ROUND_ROBIN_EN.
- **Defined:** when both sides are pending at grant time, the side not granted last wins. A last-grant bit resets to "instruction", so the first contested grant goes to data.
- **Undefined:** data always wins contested grants. Uncontested grants are identical in both builds.

## Test plan
- **Single I read:** cpui_request with addr 0x0000_0100 at cycle 5; memory acks at cycle 8 with rdata 0xDEADBEEF.
  - mem_request at 6 with mem_addr 0x100, mem_write=0.
  - cpui_ack at 8 with cpui_rdata 0xDEADBEEF; cpud_ack stays 0.
- **Single D write:** addr 0x2000, byte_enable 4'b0011, wdata 0x1234_5678.
  - mem fields match the request exactly.
  - cpud_ack on the mem_ack cycle; cpui_ack never asserts.
- **Simultaneous I and D requests at cycle 10, memory acks 2 cycles after each request:**
  - D is served first: mem_request 11, ack 13.
  - I follows: mem_request 14, ack 16.
  - With CPU_ARB_ROUND_ROBIN_EN, a second contested pair is served I-first.
- **D request arrives while an I transaction is in flight:**
  - D is held until the I ack at cycle M.
  - D's mem_request is at M+1 with its captured wdata. The bench changes the cpud_* inputs after the pulse to confirm capture.
- **Reset mid-operation:** reset at the cycle after mem_request, with a stale mem_ack arriving 2 cycles later.
  - No cpui_ack or cpud_ack.
  - All outputs hold their reset values; the next request is served normally.
- **Stray mem_ack in IDLE:** mem_ack with rdata 0xFFFF_FFFF → both acks stay 0 and the state stays IDLE.
